// File: rtl/cordic_q824_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cordic_q824_pkg
//  Purpose  : Shared constants and types for the Q8.24 CORDIC blocks.
//             Holds the fixed-point pi constants, the CORDIC gain
//             reciprocal, the arctangent table (atan(2^-i) in Q8.24,
//             round-to-nearest) and the vectoring FSM state type.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package cordic_q824_pkg;

  localparam int FRAC_W = 24;

  localparam logic signed [31:0] PI      = 32'sd52707179;
  localparam logic signed [31:0] HALF_PI = 32'sd26353589;
  // 1/K for the infinite-iteration CORDIC gain, Q8.24.
  localparam logic signed [31:0] K_INV   = 32'sd10188014;

  localparam int ATAN_N = 31;

  // atan(2^-i) * 2^24, rounded to nearest. Entries from i=25 round to 0.
  localparam logic [31:0] ATAN [ATAN_N] = '{
    32'd13176795, 32'd7778716, 32'd4110060, 32'd2086331,
    32'd1047214,  32'd524117,  32'd262123,  32'd131069,
    32'd65536,    32'd32768,   32'd16384,   32'd8192,
    32'd4096,     32'd2048,    32'd1024,    32'd512,
    32'd256,      32'd128,     32'd64,      32'd32,
    32'd16,       32'd8,       32'd4,       32'd2,
    32'd1,        32'd0,       32'd0,       32'd0,
    32'd0,        32'd0,       32'd0
  };

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PREROT = 3'd1,
    ST_ITER   = 3'd2,
    ST_SCALE  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/atan_lut_q824.sv
`default_nettype none
// ============================================================================
//  Module   : atan_lut_q824
//  Purpose  : Combinational lookup of atan(2^-idx) in Q8.24 from the shared
//             package table. Indices beyond the table return 0.
//  Ports    : idx      in  5   micro-rotation index
//             atan_val out 32  atan(2^-idx), Q8.24, non-negative
//  Revision : 1.0 - initial release
// ============================================================================
module atan_lut_q824
  import cordic_q824_pkg::*;
(
  input  logic [4:0]  idx,
  output logic [31:0] atan_val
);

  always_comb begin
    atan_val = '0;
    if (idx < 5'(ATAN_N)) begin
      atan_val = ATAN[idx];
    end
  end

endmodule
`default_nettype wire

// File: rtl/atan2_cordic_q824.sv
`default_nettype none
// ============================================================================
//  Module   : atan2_cordic_q824
//  Purpose  : Iterative vectoring-mode CORDIC converting a Q8.24 Cartesian
//             pair (x, y) to a polar angle (radians) and magnitude.
//             One conversion in flight; valid/ready on both sides.
//  Ports    : clk        in  1   clock, rising edge
//             rst        in  1   asynchronous active-high reset
//             in_valid   in  1   input pair valid
//             in_ready   out 1   block can accept a pair (IDLE only)
//             in_x       in  32  signed Q8.24 real part
//             in_y       in  32  signed Q8.24 imaginary part
//             out_valid  out 1   result valid (DONE)
//             out_ready  in  1   downstream accepts result
//             out_angle  out 32  signed Q8.24 radians, (-pi, pi]
//             out_mag    out 32  Q8.24 magnitude, saturated, >= 0
//  Revision : 1.0 - initial release
// ============================================================================
module atan2_cordic_q824
  import cordic_q824_pkg::*;
#(
  parameter int ITERS = 24,
  parameter int GUARD = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  input  logic [31:0] in_y,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_angle,
  output logic [31:0] out_mag
);

  localparam int         DW        = 32 + GUARD;
  localparam logic [4:0] ITER_LAST = 5'(ITERS - 1);

  state_t state, state_nxt;

  logic signed [DW-1:0] x_acc, y_acc;
  logic signed [DW-1:0] x_shift, y_shift;
  logic signed [31:0]   z_acc;
  logic [4:0]           iter_cnt;
  logic                 zero_flag;
  logic [31:0]          atan_val;

  logic signed [63:0]   prod;
  logic signed [63:0]   scaled;
  logic [31:0]          mag_sat;
  logic [31:0]          angle_fin;

  atan_lut_q824 u_atan_lut (
    .idx      (iter_cnt),
    .atan_val (atan_val)
  );

  assign x_shift = x_acc >>> iter_cnt;
  assign y_shift = y_acc >>> iter_cnt;

  // Gain correction: x is non-negative after convergence, so only the
  // upper bound normally matters; the lower clamp keeps out_mag >= 0.
  assign prod   = 64'(x_acc) * 64'(K_INV);
  assign scaled = prod >>> FRAC_W;

  always_comb begin
    mag_sat = scaled[31:0];
    if (scaled > 64'sh0000_0000_7FFF_FFFF) begin
      mag_sat = 32'h7FFF_FFFF;
    end else if (scaled < 64'sd0) begin
      mag_sat = '0;
    end
  end

  // Rounding can push the accumulator a few LSB past +/-pi; fold it back
  // into (-pi, pi] so the x<0, y~0 case never reports -pi.
  always_comb begin
    angle_fin = z_acc;
    if (zero_flag) begin
      angle_fin = '0;
    end else if (z_acc > PI) begin
      angle_fin = PI;
    end else if (z_acc <= -PI) begin
      angle_fin = -PI + 32'sd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ST_PREROT;
      end
      ST_PREROT: state_nxt = ST_ITER;
      ST_ITER:   if (iter_cnt == ITER_LAST) state_nxt = ST_SCALE;
      ST_SCALE:  state_nxt = ST_DONE;
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ST_IDLE;
      end
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_acc     <= '0;
      y_acc     <= '0;
      z_acc     <= '0;
      iter_cnt  <= '0;
      zero_flag <= 1'b0;
      out_angle <= '0;
      out_mag   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            x_acc    <= {{GUARD{in_x[31]}}, in_x};
            y_acc    <= {{GUARD{in_y[31]}}, in_y};
            iter_cnt <= '0;
          end
        end
        ST_PREROT: begin
          // Fold left half-plane into the right so the micro-rotations
          // only need to cover +/-pi/2. Guard bits absorb -(-128.0).
          if (x_acc[DW-1] && !y_acc[DW-1]) begin
            x_acc <= y_acc;
            y_acc <= -x_acc;
            z_acc <= HALF_PI;
          end else if (x_acc[DW-1] && y_acc[DW-1]) begin
            x_acc <= -y_acc;
            y_acc <= x_acc;
            z_acc <= -HALF_PI;
          end else begin
            z_acc <= '0;
          end
          zero_flag <= (x_acc == '0) && (y_acc == '0);
        end
        ST_ITER: begin
          if (!y_acc[DW-1]) begin
            x_acc <= x_acc + y_shift;
            y_acc <= y_acc - x_shift;
            z_acc <= z_acc + $signed(atan_val);
          end else begin
            x_acc <= x_acc - y_shift;
            y_acc <= y_acc + x_shift;
            z_acc <= z_acc - $signed(atan_val);
          end
          iter_cnt <= iter_cnt + 5'd1;
        end
        ST_SCALE: begin
          out_angle <= angle_fin;
          out_mag   <= zero_flag ? 32'd0 : mag_sat;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_atan2_cordic_q824.sv
`default_nettype none
// ============================================================================
//  Module   : tb_atan2_cordic_q824
//  Purpose  : Self-checking bench for atan2_cordic_q824. Expected angle and
//             magnitude come from real-valued atan2/sqrt of the inputs.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_atan2_cordic_q824;

  localparam int ITERS = 24;
  localparam int LAT   = ITERS + 2;
  localparam int ONE   = 16777216;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic [31:0] in_y;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_angle;
  logic [31:0] out_mag;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clk = ~clk;

  atan2_cordic_q824 #(.ITERS(ITERS), .GUARD(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .in_y      (in_y),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_angle (out_angle),
    .out_mag   (out_mag)
  );

  task automatic check(input string tag, input longint got, input longint exp, input longint tol);
    longint d;
    chk_cnt++;
    d = got - exp;
    if (d < 0) d = -d;
    if (d > tol) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  function automatic longint ref_angle(input int x, input int y);
    real a;
    if (x == 0 && y == 0) return 0;
    a = $atan2($itor(y), $itor(x)) * 16777216.0;
    return longint'($rtoi(a + ((a >= 0.0) ? 0.5 : -0.5)));
  endfunction

  function automatic real ref_mag(input int x, input int y);
    real rx, ry;
    rx = $itor(x);
    ry = $itor(y);
    return $sqrt(rx * rx + ry * ry);
  endfunction

  task automatic send(input int x, input int y);
    int guard_cnt;
    guard_cnt = 0;
    @(negedge clk);
    while (!in_ready && guard_cnt < 100) begin
      @(negedge clk);
      guard_cnt++;
    end
    in_valid = 1'b1;
    in_x     = x;
    in_y     = y;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input int x, input int y);
    real    m;
    longint em, tm;
    if (x == 0 && y == 0) begin
      check({tag, "_ang"}, longint'($signed(out_angle)), 0, 0);
      check({tag, "_mag"}, longint'(out_mag), 0, 0);
    end else begin
      m  = ref_mag(x, y);
      tm = 64 + longint'(m / 1048576.0) + 1;
      if (m > 2147483647.0 + $itor(tm)) begin
        em = 64'h7FFF_FFFF;
        tm = 0;
      end else begin
        em = longint'(m);
        if (em > 64'h7FFF_FFFF) em = 64'h7FFF_FFFF;
      end
      check({tag, "_ang"}, longint'($signed(out_angle)), ref_angle(x, y), 64);
      check({tag, "_mag"}, longint'(out_mag), em, tm);
    end
  endtask

  task automatic take_result(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check({tag, "_vld_drop"}, longint'(out_valid), 0, 0);
    check({tag, "_rdy_back"}, longint'(in_ready), 1, 0);
  endtask

  task automatic run_case(input string tag, input int x, input int y);
    int lat;
    send(x, y);
    check({tag, "_busy"}, longint'(in_ready), 0, 0);
    wait_valid(lat);
    check({tag, "_lat"}, lat, LAT, 0);
    check_result(tag, x, y);
    take_result(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got still running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int     lat;
    longint a0, m0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_x      = '0;
    in_y      = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  longint'(in_ready), 1, 0);
    check("rst_out_valid", longint'(out_valid), 0, 0);
    check("rst_angle",     longint'(out_angle), 0, 0);
    check("rst_mag",       longint'(out_mag), 0, 0);
    @(negedge clk);
    rst = 1'b0;

    run_case("p1_0",   ONE, 0);
    run_case("p0_1",   0, ONE);
    run_case("m1_0",   -ONE, 0);
    check("m1_0_pos", longint'(out_angle[31]), 0, 0);
    run_case("p1_p1",  ONE, ONE);
    run_case("m1_m1",  -ONE, -ONE);
    run_case("zero",   0, 0);
    run_case("m128",   int'(32'h8000_0000), int'(32'h8000_0000));
    check("m128_sat", longint'(out_mag), 64'h7FFF_FFFF, 0);
    run_case("p0_m1",  0, -ONE);
    run_case("m1_p1",  -ONE, ONE);

    // Backpressure: hold the result for 10 cycles.
    send(ONE, ONE);
    wait_valid(lat);
    check("bp_lat", lat, LAT, 0);
    check_result("bp", ONE, ONE);
    a0 = longint'(out_angle);
    m0 = longint'(out_mag);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      check("bp_hold_vld",  longint'(out_valid), 1, 0);
      check("bp_hold_rdy",  longint'(in_ready), 0, 0);
      check("bp_hold_ang",  longint'(out_angle), a0, 0);
      check("bp_hold_mag",  longint'(out_mag), m0, 0);
    end
    take_result("bp");
    // Present the next pair in the very cycle after the handshake.
    in_valid = 1'b1;
    in_x     = ONE;
    in_y     = -ONE;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("bp_next_acc", longint'(in_ready), 0, 0);
    wait_valid(lat);
    check("bp_next_lat", lat, LAT, 0);
    check_result("bp_next", ONE, -ONE);
    take_result("bp_next");

    // Reset in the middle of the iterations.
    send(ONE, ONE / 2);
    repeat (11) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_vld",  longint'(out_valid), 0, 0);
    check("mid_rst_rdy",  longint'(in_ready), 1, 0);
    check("mid_rst_ang",  longint'(out_angle), 0, 0);
    check("mid_rst_mag",  longint'(out_mag), 0, 0);
    @(negedge clk);
    rst = 1'b0;
    run_case("post_rst", ONE, 0);

    for (int n = 0; n < 16; n++) begin
      int     rx, ry;
      longint ax, ay;
      do begin
        rx = $urandom;
        ry = $urandom;
        rx = rx >>> $urandom_range(0, 7);
        ry = ry >>> $urandom_range(0, 7);
        ax = (rx < 0) ? -longint'(rx) : longint'(rx);
        ay = (ry < 0) ? -longint'(ry) : longint'(ry);
      end while (ax < ONE && ay < ONE);
      run_case("rand", rx, ry);
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
